// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a separate occupancy counter and show-ahead head.
module sync_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_byte_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; stale entries are never visible once the level is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back-to-back while data is queued.
// Handshake: a byte is taken on a rising clk edge where tx_valid_i && tx_ready_o; tx_data_i is ignored otherwise.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic                        uart_tx,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output uart_tx_state_t              dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end

  uart_tx_state_t state, state_n;
  logic [CNT_W-1:0] baud, baud_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_q, tx_n;
  logic             ready_q, busy_q;
  logic             push, pop, bit_end;
  logic [7:0]       head;
  logic             full, empty;
  logic [LW-1:0]    level, level_n;

  assign push = tx_valid_i && ready_q && !full;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (tx_data_i),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bit_end = (baud == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n    = '0;
          tx_n      = shift[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    level_n = level;
    if (push && !pop)      level_n = level + 1'b1;
    else if (!push && pop) level_n = level - 1'b1;
  end

  // Ready and busy are computed from next-cycle occupancy so they stay exact while registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
      ready_q <= (level_n != LW'(FIFO_DEPTH));
      busy_q  <= (state_n != IDLE) || (level_n != '0);
    end
  end

  assign uart_tx      = tx_q;
  assign tx_ready_o   = ready_q;
  assign busy_o       = busy_q;
  assign fifo_level_o = level;
  assign dbg_state    = state;

endmodule
